// File: rtl/note_pkg.sv
// Shared types and constants for the note chart spawner and its output FIFO.
package note_pkg;

  localparam int          NUM_LANES          = 4;
  localparam logic [15:0] NOTE_SENTINEL_TIME = 16'hFFFF;

  typedef struct packed {
    logic [$clog2(NUM_LANES)-1:0] lane;
    logic [15:0]                  hit_time;
  } note_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CHECK,
    ST_ARMED,
    ST_DONE
  } spawn_state_e;

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of note_t with flush; head reads zero while empty.
module note_fifo
  import note_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  note_t wdata,
  output note_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  note_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot a same-cycle push needs, so full does not block that push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers define what is valid, and
  // rdata is masked while empty so the outputs still read zero straight out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/note_spawner.sv
// Walks a time-sorted note chart ROM and queues notes that fall due within LEAD_FRAMES.
// Optional: define NOTE_SPAWNER_SKIP_LATE_EN to drop already-missed entries and count them.
module note_spawner
  import note_pkg::*;
#(
  parameter int CHART_DEPTH = 1024,
  parameter int LEAD_FRAMES = 60,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_sign,
  input  logic                           stop_sign,
  input  logic                           new_frame,
  input  logic [15:0]                    un_time,
  output logic [$clog2(CHART_DEPTH)-1:0] rom_addr,
  input  logic [17:0]                    rom_data,
  output logic                           note_valid,
  input  logic                           note_ready,
  output logic [1:0]                     note_lane,
  output logic [15:0]                    note_time,
  output logic                           chart_done,
  output logic [15:0]                    skip_cnt
);

  localparam int               PTR_W    = $clog2(CHART_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CHART_DEPTH - 1);

  spawn_state_e     state;
  spawn_state_e     next_state;
  logic [PTR_W-1:0] ptr;
  note_t            head;
  note_t            fifo_head;
  logic             new_frame_d;
  logic             frame_edge;
  logic             is_sentinel;
  logic             is_due;
  logic             skip_late;
  logic             last_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             advance;

  assign frame_edge  = new_frame & ~new_frame_d;
  assign is_sentinel = (head.hit_time == NOTE_SENTINEL_TIME);
  // 17-bit compare so un_time near the top of its range cannot wrap the window.
  assign is_due      = ({1'b0, head.hit_time} <= ({1'b0, un_time} + 17'(LEAD_FRAMES)));
  assign last_entry  = (ptr == LAST_PTR);

  // NOTE: state-holding logic uses non-blocking assignments only; the comb
  // processes below use blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    if (stop_sign) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start_sign) next_state = ST_FETCH;
        ST_FETCH: next_state = ST_WAIT;
        ST_WAIT:  next_state = ST_CHECK;
        ST_CHECK: begin
          if (is_sentinel)                           next_state = ST_DONE;
          else if (skip_late || (is_due && !fifo_full)) next_state = last_entry ? ST_DONE : ST_FETCH;
          else if (!is_due)                          next_state = ST_ARMED;
        end
        ST_ARMED: if (frame_edge) next_state = ST_CHECK;
        ST_DONE:  next_state = ST_DONE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // A due note waits in CHECK while the FIFO is full; it is never dropped.
  always_comb begin
    push    = 1'b0;
    advance = 1'b0;
    if (state == ST_CHECK && !stop_sign && !is_sentinel) begin
      if (skip_late) begin
        advance = 1'b1;
      end else if (is_due && !fifo_full) begin
        push    = 1'b1;
        advance = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      head        <= '0;
      new_frame_d <= 1'b0;
    end else begin
      new_frame_d <= new_frame;
      if (stop_sign || state == ST_IDLE) ptr  <= '0;
      else if (advance && !last_entry)   ptr  <= ptr + 1'b1;
      if (state == ST_WAIT)              head <= rom_data;
    end
  end

`ifdef NOTE_SPAWNER_SKIP_LATE_EN
  logic skip_inc;

  assign skip_late = (head.hit_time < un_time);
  assign skip_inc  = advance & ~push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   skip_cnt <= '0;
    else if (stop_sign)                          skip_cnt <= '0;
    else if (skip_inc && skip_cnt != 16'hFFFF)   skip_cnt <= skip_cnt + 16'd1;
  end
`else
  assign skip_late = 1'b0;
  assign skip_cnt  = '0;
`endif

  note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (note_ready),
    .flush (stop_sign),
    .wdata (head),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rom_addr   = ptr;
  assign chart_done = (state == ST_DONE);
  assign note_valid = ~fifo_empty;
  assign note_lane  = fifo_head.lane;
  assign note_time  = fifo_head.hit_time;

endmodule

// File: tb/tb_note_spawner.sv
// Self-checking bench for note_spawner: directed scenarios plus randomized charts
// scored against an ordered expected-note queue built from the chart contents.
`timescale 1ns/1ps
module tb_note_spawner;
  import note_pkg::*;

  localparam int CHART_DEPTH = 1024;
  localparam int LEAD        = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_sign;
  logic        stop_sign;
  logic        new_frame;
  logic [15:0] un_time;
  logic [9:0]  rom_addr;
  logic [17:0] rom_data;
  logic        note_valid;
  logic        note_ready;
  logic [1:0]  note_lane;
  logic [15:0] note_time;
  logic        chart_done;
  logic [15:0] skip_cnt;

  logic [17:0] chart [CHART_DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= chart[rom_addr];

  note_spawner #(.CHART_DEPTH(CHART_DEPTH), .LEAD_FRAMES(LEAD), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_sign (start_sign),
    .stop_sign  (stop_sign),
    .new_frame  (new_frame),
    .un_time    (un_time),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_lane  (note_lane),
    .note_time  (note_time),
    .chart_done (chart_done),
    .skip_cnt   (skip_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_chart();
    for (int i = 0; i < CHART_DEPTH; i++) chart[i] = {2'd0, NOTE_SENTINEL_TIME};
  endtask

  task automatic pulse_start();
    start_sign = 1'b1;
    tick();
    start_sign = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_sign = 1'b1;
    tick();
    stop_sign = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, note_valid, 0);
    check({tag, "_lane"},  note_lane,  0);
    check({tag, "_time"},  note_time,  0);
    check({tag, "_addr"},  rom_addr,   0);
    check({tag, "_done"},  chart_done, 0);
    check({tag, "_skip"},  skip_cnt,   0);
  endtask

  task automatic recv(input string tag, input logic [1:0] el, input logic [15:0] et);
    int k;
    k = 0;
    while (!note_valid && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_seen"}, note_valid, 1);
    check({tag, "_lane"}, note_lane,  el);
    check({tag, "_time"}, note_time,  et);
    note_ready = 1'b1;
    tick();
    note_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!chart_done && k < 200) begin
      tick();
      k++;
    end
    check(tag, chart_done, 1);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check_zero_outputs(tag);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    note_t exp_q[$];
    note_t e;
    int    n_notes, h, u0, cyc;
    bit    early;

    reset = 1'b1; start_sign = 1'b0; stop_sign = 1'b0; new_frame = 1'b0;
    note_ready = 1'b0; un_time = '0;
    clear_chart();
    tick(2);
    check_zero_outputs("rst");
    reset = 1'b0;
    tick();

    // Two notes due immediately, then the sentinel.
    clear_chart();
    chart[0] = {2'd1, 16'd60};
    chart[1] = {2'd2, 16'd60};
    un_time = 16'd0;
    pulse_start();
    check("t1_addr0", rom_addr, 0);
    tick(2);
    check("t1_not_yet", note_valid, 0);
    tick();
    check("t1_first_valid", note_valid, 1);
    recv("t1a", 2'd1, 16'd60);
    recv("t1b", 2'd2, 16'd60);
    wait_done("t1_done");
    check("t1_empty", note_valid, 0);
    apply_reset("t1_rst");

    // Single note at 200, one frame at a time: spawns on the frame where un_time = 140.
    clear_chart();
    chart[0] = {2'd0, 16'd200};
    un_time = 16'd0;
    pulse_start();
    tick(6);
    early = 1'b0;
    for (int t = 1; t < 140; t++) begin
      un_time = 16'(t);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      tick();
      if (note_valid) early = 1'b1;
    end
    check("t2_no_early", early, 0);
    un_time = 16'd140;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("t2_edge_plus1", note_valid, 0);
    tick();
    check("t2_edge_plus2", note_valid, 1);
    check("t2_time", note_time, 200);
    check("t2_lane", note_lane, 0);
    apply_reset("t2_rst");

    // Ten due notes against a stalled consumer: FIFO fills at 8, nothing lost.
    clear_chart();
    for (int i = 0; i < 10; i++) chart[i] = {2'(i % 4), 16'd50};
    un_time = 16'd0;
    pulse_start();
    tick(60);
    check("t3_valid", note_valid, 1);
    check("t3_ptr_held", rom_addr, 8);
    tick(10);
    check("t3_ptr_still", rom_addr, 8);
    check("t3_not_done", chart_done, 0);
    for (int i = 0; i < 10; i++) recv($sformatf("t3_n%0d", i), 2'(i % 4), 16'd50);
    wait_done("t3_done");
    apply_reset("t3_rst");

    // Stop while armed with three notes queued, then restart from the top.
    clear_chart();
    chart[0] = {2'd0, 16'd10};
    chart[1] = {2'd1, 16'd20};
    chart[2] = {2'd2, 16'd30};
    chart[3] = {2'd3, 16'd500};
    un_time = 16'd0;
    pulse_start();
    tick(30);
    check("t4_queued", note_valid, 1);
    check("t4_armed_addr", rom_addr, 3);
    pulse_stop();
    check("t4_flushed", note_valid, 0);
    check("t4_addr_clr", rom_addr, 0);
    check("t4_done_clr", chart_done, 0);
    tick(3);
    check("t4_idle", note_valid, 0);
    pulse_start();
    check("t4_restart_addr", rom_addr, 0);
    recv("t4_first", 2'd0, 16'd10);
    apply_reset("t4_rst");

    // An entry that is already in the past when first checked.
    clear_chart();
    chart[0] = {2'd1, 16'd5};
    un_time = 16'd20;
    pulse_start();
    tick(20);
`ifdef NOTE_SPAWNER_SKIP_LATE_EN
    check("t5_dropped", note_valid, 0);
    check("t5_skip", skip_cnt, 1);
    check("t5_done", chart_done, 1);
`else
    check("t5_pushed", note_valid, 1);
    check("t5_time", note_time, 5);
    check("t5_lane", note_lane, 1);
    check("t5_skip", skip_cnt, 0);
`endif
    pulse_stop();
    check("t5_skip_clr", skip_cnt, 0);

    // Asynchronous reset mid-stream.
    clear_chart();
    chart[0] = {2'd2, 16'd7};
    chart[1] = {2'd3, 16'd8};
    un_time = 16'd0;
    pulse_start();
    tick(10);
    check("t6_pre", note_valid, 1);
    apply_reset("t6_async");
    tick(5);
    check("t6_stays_idle", note_valid, 0);
    check("t6_addr", rom_addr, 0);

    // Randomized charts: notes must come out in chart order, and only once due.
    for (int it = 0; it < 6; it++) begin
      exp_q.delete();
      clear_chart();
      n_notes = $urandom_range(20, 1);
      u0      = $urandom_range(500, 0);
      h       = u0 + $urandom_range(100, 0);
      for (int i = 0; i < n_notes; i++) begin
        e.lane     = 2'($urandom_range(3, 0));
        e.hit_time = 16'(h);
        chart[i]   = e;
        exp_q.push_back(e);
        h += $urandom_range(15, 0);
      end
      un_time = 16'(u0);
      pulse_start();
      cyc = 0;
      while ((exp_q.size() > 0 || !chart_done) && cyc < 5000) begin
        note_ready = 1'($urandom_range(1, 0));
        if (note_valid && note_ready) begin
          if (exp_q.size() == 0) begin
            check("rnd_extra_note", note_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_lane", note_lane, e.lane);
            check("rnd_time", note_time, e.hit_time);
            check("rnd_due", ({1'b0, note_time} <= ({1'b0, un_time} + 17'(LEAD))), 1);
          end
        end
        if (cyc % 6 == 0 && !note_valid) begin
          un_time   = un_time + 16'd1;
          new_frame = 1'b1;
        end else begin
          new_frame = 1'b0;
        end
        tick();
        cyc++;
      end
      note_ready = 1'b0;
      new_frame  = 1'b0;
      check("rnd_all_delivered", exp_q.size(), 0);
      check("rnd_done", chart_done, 1);
      pulse_stop();
      check("rnd_stop_done_clr", chart_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
